// File: rtl/bf16_fma_issue_pipe.sv
// bf16_fma_issue_pipe: two-stage valid/ready wrapper around a combinational
// bfloat16 FMA core (result = a*b + c). Stage 1 registers operands onto the
// core inputs; stage 2 captures the core result and overflow flag for
// downstream. Also keeps a sticky overflow flag and a retired-op counter.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready, a/b/c  operand triple handshake
//   fma_a/b/c                 registered operands driven to the FMA core
//   fma_result/fma_ov         combinational FMA core outputs
//   out_valid/out_ready       result handshake
//   out_result/out_ov         registered result and its overflow flag
//   ov_sticky/clear_sticky    sticky overflow flag and its clear
//   op_count                  results retired, wraps at 2^COUNT_W
module bf16_fma_issue_pipe #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        a,
  input  logic [15:0]        b,
  input  logic [15:0]        c,
  output logic [15:0]        fma_a,
  output logic [15:0]        fma_b,
  output logic [15:0]        fma_c,
  input  logic [15:0]        fma_result,
  input  logic               fma_ov,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_result,
  output logic               out_ov,
  output logic               ov_sticky,
  input  logic               clear_sticky,
  output logic [COUNT_W-1:0] op_count
);

  logic s1_valid;
  logic s2_free;
  logic s1_adv;
  logic accept;
  logic retire;

  // Handshake qualifiers; in_ready deliberately ignores in_valid.
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  // Stage 1: operand register feeding the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      fma_a    <= 16'h0000;
      fma_b    <= 16'h0000;
      fma_c    <= 16'h0000;
    end else if (accept) begin
      s1_valid <= 1'b1;
      fma_a    <= a;
      fma_b    <= b;
      fma_c    <= c;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register; holds steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_ov     <= 1'b0;
    end else if (s1_adv) begin
      out_valid  <= 1'b1;
      out_result <= fma_result;
      out_ov     <= fma_ov;
    end else if (retire) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky overflow: a fresh overflow capture beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_sticky <= 1'b0;
    end else if (s1_adv && fma_ov) begin
      ov_sticky <= 1'b1;
    end else if (clear_sticky) begin
      ov_sticky <= 1'b0;
    end
  end

  // Retired-operation counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (retire) begin
      op_count <= op_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bf16_fma_issue_pipe.sv
// Scoreboard bench for bf16_fma_issue_pipe. A stand-in FMA core returns
// hand-computed bf16 results for a small set of operand triples; the driver
// pushes each accepted op's expected result, the monitor pops on retirement.
// A second instance with COUNT_W=2 shares the stimulus to exercise wrap.
module tb_bf16_fma_issue_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [15:0] a, b, c;
  logic [15:0] fma_a, fma_b, fma_c, fma_a2, fma_b2, fma_c2;
  logic [15:0] fma_result, fma_result2;
  logic        fma_ov, fma_ov2;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [15:0] out_result, out_result2;
  logic        out_ov, out_ov2;
  logic        ov_sticky, ov_sticky2;
  logic        clear_sticky;
  logic [15:0] op_count;
  logic [1:0]  op_count2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_q[$];
  int exp_count = 0;

  always #5 clk = ~clk;

  bf16_fma_issue_pipe #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_result(fma_result), .fma_ov(fma_ov), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_ov(out_ov),
    .ov_sticky(ov_sticky), .clear_sticky(clear_sticky), .op_count(op_count)
  );

  bf16_fma_issue_pipe #(.COUNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .c(c), .fma_a(fma_a2), .fma_b(fma_b2), .fma_c(fma_c2),
    .fma_result(fma_result2), .fma_ov(fma_ov2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_result(out_result2), .out_ov(out_ov2),
    .ov_sticky(ov_sticky2), .clear_sticky(clear_sticky), .op_count(op_count2)
  );

  // Stand-in FMA core: known triples only, anything else yields a marker.
  function automatic logic [16:0] core(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
    case ({x, y, z})
      {16'h4160, 16'h41C0, 16'h41E0}: core = {1'b0, 16'h43B6}; // 14*24+28=364
      {16'h3F80, 16'h3F80, 16'h3F80}: core = {1'b0, 16'h4000}; // 1*1+1=2
      {16'h4000, 16'h4000, 16'h0000}: core = {1'b0, 16'h4080}; // 2*2+0=4
      {16'h3F80, 16'h4000, 16'h3F80}: core = {1'b0, 16'h4040}; // 1*2+1=3
      {16'h4040, 16'h4000, 16'h3F80}: core = {1'b0, 16'h40E0}; // 3*2+1=7
      {16'h7F00, 16'h7F00, 16'h0000}: core = {1'b1, 16'h7F80}; // 2^254 -> inf
      default:                        core = {1'b0, 16'hDEAD};
    endcase
  endfunction

  assign {fma_ov, fma_result}   = core(fma_a, fma_b, fma_c);
  assign {fma_ov2, fma_result2} = core(fma_a2, fma_b2, fma_c2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present an op (caller sits just after a rising edge), wait for acceptance,
  // record the expected response, and return just after the accepting edge.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vc,
                      input logic [15:0] er, input logic eo, output int waited);
    a = va; b = vb; c = vc; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", waited);
    end else begin
      exp_q.push_back({eo, er});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: retire-side scoreboard, counters, and stall stability.
  logic        stall_prev = 1'b0;
  logic [16:0] stall_val;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_count  = 0;
      stall_prev = 1'b0;
    end else begin
      chk("op_count", 32'(op_count), 32'(exp_count[15:0]));
      chk("op_count_w2", 32'(op_count2), 32'(exp_count[1:0]));
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({out_ov, out_result}), 32'(stall_val));
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_ov, out_result};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out: result 0x%0h with empty scoreboard", out_result);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("out_result", 32'(out_result), 32'(e[15:0]));
          chk("out_ov", 32'(out_ov), 32'(e[16]));
          chk("w2_result", 32'({out_ov2, out_result2}), 32'(e));
        end
        exp_count++;
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0;
    out_ready = 1'b1; clear_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fma_a", 32'(fma_a), 32'h0);
    chk("rst_out_result", 32'(out_result), 32'h0);
    chk("rst_ov_sticky", 32'(ov_sticky), 32'd0);
    @(posedge clk); #1;

    // 1: single op, latency of two edges after acceptance
    send(16'h4160, 16'h41C0, 16'h41E0, 16'h43B6, 1'b0, w);
    @(negedge clk);
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    drain();
    chk("single_count", 32'(op_count), 32'd1);

    // 2: four back-to-back ops, in_ready never drops
    send(16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, w); chk("stream_wait0", 32'(w), 32'd0);
    send(16'h4000, 16'h4000, 16'h0000, 16'h4080, 1'b0, w); chk("stream_wait1", 32'(w), 32'd0);
    send(16'h3F80, 16'h4000, 16'h3F80, 16'h4040, 1'b0, w); chk("stream_wait2", 32'(w), 32'd0);
    send(16'h4040, 16'h4000, 16'h3F80, 16'h40E0, 1'b0, w); chk("stream_wait3", 32'(w), 32'd0);
    drain();
    chk("stream_count", 32'(op_count), 32'd5);

    // 3: backpressure, two ops fill the pipe, third waits
    out_ready = 1'b0;
    send(16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, w);
    send(16'h4000, 16'h4000, 16'h0000, 16'h4080, 1'b0, w);
    fork
      send(16'h3F80, 16'h4000, 16'h3F80, 16'h4040, 1'b0, w);
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_result", 32'(out_result), 32'h4000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    drain();
    chk("bp_count", 32'(op_count), 32'd8);

    // 4: overflow, sticky set-beats-clear, then clear alone
    send(16'h7F00, 16'h7F00, 16'h0000, 16'h7F80, 1'b1, w);
    drain();
    chk("ov_sticky_set", 32'(ov_sticky), 32'd1);
    send(16'h7F00, 16'h7F00, 16'h0000, 16'h7F80, 1'b1, w);
    clear_sticky = 1'b1;            // coincides with the capture edge
    @(posedge clk); #1;
    clear_sticky = 1'b0;
    @(negedge clk);
    chk("ov_set_wins", 32'(ov_sticky), 32'd1);
    @(posedge clk); #1;
    drain();
    clear_sticky = 1'b1;
    @(posedge clk); #1;
    clear_sticky = 1'b0;
    @(negedge clk);
    chk("ov_cleared", 32'(ov_sticky), 32'd0);
    @(posedge clk); #1;

    // 5: reset with two ops in flight discards both
    out_ready = 1'b0;
    send(16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, w);
    send(16'h4000, 16'h4000, 16'h0000, 16'h4080, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_op_count", 32'(op_count), 32'd0);
    repeat (4) @(negedge clk);     // monitor flags any stale result
    @(posedge clk); #1;

    // 6: five retirements; narrow counter steps 1,2,3,0,1
    send(16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, w);
    send(16'h4000, 16'h4000, 16'h0000, 16'h4080, 1'b0, w);
    send(16'h3F80, 16'h4000, 16'h3F80, 16'h4040, 1'b0, w);
    send(16'h4040, 16'h4000, 16'h3F80, 16'h40E0, 1'b0, w);
    send(16'h4160, 16'h41C0, 16'h41E0, 16'h43B6, 1'b0, w);
    drain();
    chk("wrap_count_w2", 32'(op_count2), 32'd1);
    chk("wrap_count_w16", 32'(op_count), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
